// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the UDP tx packet arbiter.
// The watchdog beat counter width applies only when UDP_TX_ARB_WDOG_EN is defined.
package udp_tx_arb_pkg;

  localparam int CNT_W         = 16;
  localparam int REQ_MAX       = 4;
  localparam int MAX_BEATS_DEF = 750;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/udp_tx_arb_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first set request bit
// at or above i_ptr, wrapping modulo N. Shared with the rx-side port arbiter.
module rr_pick
  import udp_tx_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  always_comb begin : p_pick
    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arb.sv
// Packet-granular round-robin arbiter sharing the UDP tx datapath between REQ_N streams.
// Define UDP_TX_ARB_WDOG_EN to add the frame-length watchdog (cancel_o + DRAIN state).
module udp_tx_arb
  import udp_tx_arb_pkg::*;
#(
  parameter int REQ_N     = 2,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 2,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [REQ_N-1:0]        req_valid_i,
  input  logic [REQ_N-1:0]        req_start_i,
  input  logic [REQ_N-1:0]        req_last_i,
  input  logic [REQ_N*DATA_W-1:0] req_data_i,
  input  logic [REQ_N*LEN_W-1:0]  req_len_i,
  output logic [REQ_N-1:0]        req_ready_o,
  output logic                    valid_o,
  output logic                    start_o,
  output logic                    last_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [LEN_W-1:0]        len_o,
  input  logic                    ready_i,
  output logic                    cancel_o,
  output logic [REQ_N-1:0]        gnt_o
);

  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  if ((REQ_N < 2) || (REQ_N > REQ_MAX) || (DATA_W != 16) || (MAX_BEATS < 1)) begin : g_bad_cfg
    $error("udp_tx_arb: unsupported parameter set");
  end

  // Handshake: a beat moves when valid and ready are both high on a rising clk edge;
  // valid_o never depends on ready_i, ready may depend on valid.
  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [REQ_N-1:0] r_gnt;
  logic [REQ_N-1:0] w_pick;
  logic [REQ_N-1:0] w_cand;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_g_valid;
  logic             w_g_last;
  logic             w_hs;
  logic             w_done;

  assign w_cand = req_valid_i & req_start_i;

  rr_pick #(.N(REQ_N), .PTR_W(PTR_W)) u_pick (
    .i_req (w_cand),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (r_gnt[i]) w_gidx = PTR_W'(i);
    end
  end

  assign w_ptr_nxt = (w_gidx == PTR_W'(REQ_N - 1)) ? '0 : w_gidx + 1'b1;
  assign w_g_valid = req_valid_i[w_gidx];
  assign w_g_last  = req_last_i[w_gidx];
  assign w_hs      = (r_state == ST_BUSY) && w_g_valid && ready_i;
  assign gnt_o     = r_gnt;

`ifdef UDP_TX_ARB_WDOG_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_cancel;
  logic             w_wdog_hit;

  // The beat that brings the count to MAX_BEATS is still forwarded; the rest are dropped.
  assign w_wdog_hit = w_hs && !w_g_last && (r_cnt == CNT_W'(MAX_BEATS - 1));
  assign cancel_o   = r_cancel;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_cnt    <= '0;
      r_cancel <= 1'b0;
    end else begin
      r_cancel <= w_wdog_hit;
      if (r_state == ST_IDLE) r_cnt <= '0;
      else if (w_hs)          r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign cancel_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    valid_o     = 1'b0;
    start_o     = 1'b0;
    last_o      = 1'b0;
    data_o      = req_data_i[int'(w_gidx)*DATA_W +: DATA_W];
    len_o       = req_len_i[int'(w_gidx)*LEN_W +: LEN_W];
    req_ready_o = '0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Orphan beats are swallowed here so a broken stream cannot wedge the port.
        req_ready_o = req_valid_i & ~req_start_i;
        if (|w_cand) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        valid_o             = w_g_valid;
        start_o             = req_start_i[w_gidx];
        last_o              = w_g_last;
        req_ready_o[w_gidx] = ready_i;
        if (w_hs && w_g_last) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
`ifdef UDP_TX_ARB_WDOG_EN
        else if (w_wdog_hit) begin
          w_state_nxt = ST_DRAIN;
        end
`endif
      end
`ifdef UDP_TX_ARB_WDOG_EN
      ST_DRAIN: begin
        req_ready_o[w_gidx] = 1'b1;
        if (w_g_valid && w_g_last) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (|w_cand)) begin
        r_gnt <= w_pick;
      end else if (w_done) begin
        r_gnt <= '0;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Self-checking bench for udp_tx_arb: directed scenario tasks plus a randomized run
// compared cycle by cycle against a behavioural owner/pointer model.
module tb_udp_tx_arb;

  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int LW   = 2;
  localparam int MAXB = 4;
`ifdef UDP_TX_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic            clk;
  logic            nreset;
  logic [N-1:0]    rv, rs, rl;
  logic [N*DW-1:0] rd;
  logic [N*LW-1:0] rlen;
  logic [N-1:0]    req_ready;
  logic            valid, start, last, ready_i, cancel;
  logic [DW-1:0]   data;
  logic [LW-1:0]   len;
  logic [N-1:0]    gnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  udp_tx_arb #(.REQ_N(N), .DATA_W(DW), .LEN_W(LW), .MAX_BEATS(MAXB)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req_valid_i (rv),
    .req_start_i (rs),
    .req_last_i  (rl),
    .req_data_i  (rd),
    .req_len_i   (rlen),
    .req_ready_o (req_ready),
    .valid_o     (valid),
    .start_o     (start),
    .last_o      (last),
    .data_o      (data),
    .len_o       (len),
    .ready_i     (ready_i),
    .cancel_o    (cancel),
    .gnt_o       (gnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_beat(input int r, input logic v, input logic s, input logic l,
                          input logic [DW-1:0] d, input logic [LW-1:0] ln);
    rv[r] = v;
    rs[r] = s;
    rl[r] = l;
    rd[r*DW +: DW]   = d;
    rlen[r*LW +: LW] = ln;
  endtask

  task automatic clear_inputs();
    rv = '0; rs = '0; rl = '0; rd = '0; rlen = '0;
  endtask

  task automatic apply_reset();
    nreset  = 1'b0;
    ready_i = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    nreset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nreset  = 1'b0;
    ready_i = 1'b1;
    set_beat(0, 1'b1, 1'b1, 1'b0, 16'h1234, 2'd2);
    set_beat(1, 1'b1, 1'b0, 1'b0, 16'h5678, 2'd2);
    cyc();
    cyc();
    clear_inputs();
    nreset = 1'b1;
    samp();
    n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b exp 00", gnt); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid); else n_pass++;
    n_checks++; if (start !== 1'b0 || last !== 1'b0) $display("FAIL reset_start_last: got %b%b exp 00", start, last); else n_pass++;
    n_checks++; if (cancel !== 1'b0) $display("FAIL reset_cancel: got %b exp 0", cancel); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b exp 00", req_ready); else n_pass++;
    cyc();
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    apply_reset();
    ready_i = 1'b1;
    set_beat(0, 1'b1, 1'b1, 1'b0, w[0], 2'd2);
    samp();
    n_checks++; if (gnt !== 2'b00) $display("FAIL single_latency_gnt: got %b exp 00", gnt); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL single_start_not_ready: got %b exp 00", req_ready); else n_pass++;
    cyc();
    for (int b = 0; b < 3; b++) begin
      set_beat(0, 1'b1, (b == 0), (b == 2), w[b], 2'd2);
      samp();
      n_checks++; if (gnt !== 2'b01) $display("FAIL single_gnt_b%0d: got %b exp 01", b, gnt); else n_pass++;
      n_checks++; if (valid !== 1'b1 || data !== w[b]) $display("FAIL single_data_b%0d: got v=%b %h exp v=1 %h", b, valid, data, w[b]); else n_pass++;
      n_checks++; if (start !== (b == 0) || last !== (b == 2)) $display("FAIL single_flags_b%0d: got s=%b l=%b", b, start, last); else n_pass++;
      n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready_b%0d: got %b exp 01", b, req_ready); else n_pass++;
      cyc();
    end
    clear_inputs();
    samp();
    n_checks++; if (gnt !== 2'b00 || valid !== 1'b0) $display("FAIL single_back_idle: got gnt=%b v=%b exp 00/0", gnt, valid); else n_pass++;
    // Pointer now sits at 1: a simultaneous contest must go to req1.
    set_beat(0, 1'b1, 1'b1, 1'b1, 16'hAAAA, 2'd2);
    set_beat(1, 1'b1, 1'b1, 1'b1, 16'hBBBB, 2'd2);
    cyc();
    samp();
    n_checks++; if (gnt !== 2'b10) $display("FAIL single_ptr_advanced: got %b exp 10", gnt); else n_pass++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_alternating();
    int b [N];
    int fid [N];
    int order[$];
    int gaps[$];
    int idle_run;
    logic [N-1:0] prev;
    apply_reset();
    ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin b[i] = 0; fid[i] = 0; end
    idle_run = 0;
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++)
        set_beat(i, 1'b1, (b[i] == 0), (b[i] == 1), 16'(i*256 + fid[i]*16 + b[i]), 2'd2);
      samp();
      if (gnt == '0) idle_run++;
      else begin
        if (prev == '0) begin
          order.push_back((gnt == 2'b10) ? 1 : 0);
          if (order.size() > 1) gaps.push_back(idle_run);
        end
        idle_run = 0;
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          b[i] = b[i] ^ 1;
          if (b[i] == 0) fid[i]++;
        end
      prev = gnt;
      cyc();
    end
    clear_inputs();
    n_checks++; if (order.size() < 4) $display("FAIL alt_grant_count: got %0d exp >=4", order.size()); else n_pass++;
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      n_checks++; if (order[k] != (k % 2)) $display("FAIL alt_order_%0d: got req%0d exp req%0d", k, order[k], k % 2); else n_pass++;
    end
    for (int k = 0; k < 3 && k < gaps.size(); k++) begin
      n_checks++; if (gaps[k] != 1) $display("FAIL alt_bubble_%0d: got %0d idle cycles exp 1", k, gaps[k]); else n_pass++;
    end
    cyc();
  endtask

  task automatic test_stall();
    apply_reset();
    ready_i = 1'b1;
    set_beat(1, 1'b1, 1'b1, 1'b0, 16'h5000, 2'd2);
    samp();
    n_checks++; if (gnt !== 2'b00) $display("FAIL stall_latency: got %b exp 00", gnt); else n_pass++;
    cyc();
    samp();
    n_checks++; if (gnt !== 2'b10 || data !== 16'h5000) $display("FAIL stall_first: got gnt=%b %h exp 10 5000", gnt, data); else n_pass++;
    cyc();
    set_beat(1, 1'b1, 1'b0, 1'b0, 16'h5001, 2'd1);
    set_beat(0, 1'b1, 1'b1, 1'b1, 16'h7777, 2'd2);
    ready_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      samp();
      n_checks++; if (valid !== 1'b1 || data !== 16'h5001 || len !== 2'd1) $display("FAIL stall_hold_%0d: got v=%b %h len=%0d exp 1 5001 1", s, valid, data, len); else n_pass++;
      n_checks++; if (req_ready !== 2'b00 || gnt !== 2'b10) $display("FAIL stall_gnt_%0d: got rdy=%b gnt=%b exp 00 10", s, req_ready, gnt); else n_pass++;
      cyc();
    end
    ready_i = 1'b1;
    samp();
    n_checks++; if (req_ready !== 2'b10) $display("FAIL stall_release: got %b exp 10", req_ready); else n_pass++;
    cyc();
    set_beat(1, 1'b1, 1'b0, 1'b1, 16'h5002, 2'd2);
    samp();
    n_checks++; if (last !== 1'b1 || data !== 16'h5002) $display("FAIL stall_last: got l=%b %h exp 1 5002", last, data); else n_pass++;
    cyc();
    set_beat(1, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
    samp();
    n_checks++; if (gnt !== 2'b00 || valid !== 1'b0) $display("FAIL stall_bubble: got gnt=%b v=%b exp 00 0", gnt, valid); else n_pass++;
    cyc();
    samp();
    n_checks++; if (gnt !== 2'b01 || data !== 16'h7777 || last !== 1'b1) $display("FAIL stall_next_req0: got gnt=%b %h l=%b", gnt, data, last); else n_pass++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_orphan();
    apply_reset();
    ready_i = 1'b1;
    set_beat(0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 2'd2);
    samp();
    n_checks++; if (req_ready !== 2'b01) $display("FAIL orphan_ready: got %b exp 01", req_ready); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL orphan_valid: got %b exp 0", valid); else n_pass++;
    cyc();
    clear_inputs();
    samp();
    n_checks++; if (gnt !== 2'b00 || valid !== 1'b0) $display("FAIL orphan_no_grant: got gnt=%b v=%b exp 00 0", gnt, valid); else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    ready_i = 1'b1;
    set_beat(0, 1'b1, 1'b1, 1'b1, 16'h0101, 2'd2);
    cyc();
    cyc();
    clear_inputs();
    set_beat(1, 1'b1, 1'b1, 1'b0, 16'h0200, 2'd2);
    cyc();
    cyc();
    set_beat(1, 1'b1, 1'b0, 1'b0, 16'h0201, 2'd2);
    samp();
    n_checks++; if (gnt !== 2'b10) $display("FAIL rstmid_busy: got %b exp 10", gnt); else n_pass++;
    nreset = 1'b0;
    cyc();
    nreset = 1'b1;
    clear_inputs();
    samp();
    n_checks++; if (gnt !== 2'b00 || valid !== 1'b0 || cancel !== 1'b0) $display("FAIL rstmid_idle: got gnt=%b v=%b c=%b exp 00 0 0", gnt, valid, cancel); else n_pass++;
    set_beat(0, 1'b1, 1'b1, 1'b1, 16'h0A0A, 2'd2);
    set_beat(1, 1'b1, 1'b1, 1'b1, 16'h0B0B, 2'd1);
    cyc();
    samp();
    n_checks++; if (gnt !== 2'b01) $display("FAIL rstmid_ptr_zero: got %b exp 01", gnt); else n_pass++;
    cyc();
    set_beat(0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
    cyc();
    samp();
    n_checks++; if (gnt !== 2'b10 || data !== 16'h0B0B || len !== 2'd1) $display("FAIL rstmid_req1: got gnt=%b %h len=%0d exp 10 0b0b 1", gnt, data, len); else n_pass++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_long_frame();
    int k;
    int n_cancel;
    int exp_fwd;
    int exp_cancel;
    apply_reset();
    ready_i    = 1'b1;
    exp_fwd    = WDOG ? MAXB : 6;
    exp_cancel = WDOG ? 1 : 0;
    exp_q.delete();
    for (int i = 0; i < exp_fwd; i++) exp_q.push_back(16'hC000 + 16'(i));
    k = 0;
    n_cancel = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      set_beat(0, 1'b1, (k == 0), (k == 5), 16'hC000 + 16'(k), 2'd2);
      samp();
      if (cancel === 1'b1) n_cancel++;
      if (valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL long_extra_beat: got %h exp none", data);
        else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (data !== e) $display("FAIL long_data: got %h exp %h", data, e); else n_pass++;
        end
      end
      if (req_ready[0] === 1'b1) k++;
      cyc();
    end
    clear_inputs();
    samp();
    if (cancel === 1'b1) n_cancel++;
    n_checks++; if (k != 6) $display("FAIL long_accepted: got %0d exp 6", k); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL long_missing: got %0d left exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (n_cancel != exp_cancel) $display("FAIL long_cancel: got %0d exp %0d", n_cancel, exp_cancel); else n_pass++;
    n_checks++; if (gnt !== 2'b00 || valid !== 1'b0) $display("FAIL long_idle: got gnt=%b v=%b exp 00 0", gnt, valid); else n_pass++;
    cyc();
  endtask

  task automatic test_random();
    int bidx [N];
    int flen [N];
    bit hold [N];
    bit orph [N];
    int m_owner;
    int m_ptr;
    logic [N-1:0] exp_ready, exp_gnt, acc;
    logic exp_valid;
    int o;
    apply_reset();
    m_owner = -1;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      bidx[i] = 0; flen[i] = $urandom_range(1, 4); hold[i] = 0; orph[i] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            orph[i] = (bidx[i] == 0) && ($urandom_range(0, 9) == 0);
            set_beat(i, 1'b1, !orph[i] && (bidx[i] == 0), !orph[i] && (bidx[i] == flen[i] - 1),
                     16'($urandom), 2'($urandom_range(1, 2)));
            hold[i] = 1;
          end else begin
            rv[i] = 1'b0;
          end
        end
      end
      ready_i = ($urandom_range(0, 3) != 0);
      samp();
      exp_gnt   = '0;
      exp_ready = '0;
      exp_valid = 1'b0;
      o = m_owner;
      if (o < 0) begin
        exp_ready = rv & ~rs;
      end else begin
        exp_gnt[o]   = 1'b1;
        exp_ready[o] = ready_i;
        exp_valid    = rv[o];
      end
      n_checks++; if (gnt !== exp_gnt) $display("FAIL rnd_gnt c%0d: got %b exp %b", c, gnt, exp_gnt); else n_pass++;
      n_checks++; if (valid !== exp_valid) $display("FAIL rnd_valid c%0d: got %b exp %b", c, valid, exp_valid); else n_pass++;
      n_checks++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %b exp %b", c, req_ready, exp_ready); else n_pass++;
      n_checks++; if (cancel !== 1'b0) $display("FAIL rnd_cancel c%0d: got %b exp 0", c, cancel); else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (data !== rd[o*DW +: DW] || len !== rlen[o*LW +: LW] || start !== rs[o] || last !== rl[o])
          $display("FAIL rnd_beat c%0d: got %h/%0d/%b%b exp %h/%0d/%b%b", c, data, len, start, last,
                   rd[o*DW +: DW], rlen[o*LW +: LW], rs[o], rl[o]);
        else n_pass++;
      end
      acc = rv & exp_ready;
      if (o < 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (m_owner < 0 && rv[j] && rs[j]) m_owner = j;
        end
      end else if (rv[o] && ready_i && rl[o]) begin
        m_ptr   = (o + 1) % N;
        m_owner = -1;
      end
      cyc();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          hold[i] = 0;
          if (!orph[i]) begin
            if (bidx[i] == flen[i] - 1) begin bidx[i] = 0; flen[i] = $urandom_range(1, 4); end
            else bidx[i]++;
          end
          orph[i] = 0;
        end else if (!rv[i]) begin
          hold[i] = 0;
        end
      end
    end
    clear_inputs();
    ready_i = 1'b0;
    cyc();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nreset  = 1'b0;
    ready_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single_frame();
    test_alternating();
    test_stall();
    test_orphan();
    test_reset_mid_frame();
    test_long_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
Packet-granular round-robin arbiter that shares the single UDP tx datapath between REQ_N application streams. Each stream presents frames as valid/start/last beats with a 16-bit data word. A grant is held from the start beat to the last beat, so frames are never interleaved. Sits between the application ports and the UDP/IP tx encapsulation.

Parameters:
REQ_N, 2, number of requesters (2..4).
DATA_W, 16, beat width in bits; only 16 supported.
LEN_W, 2, byte-count width; len = valid bytes in beat, 1..2, LSB-first.
MAX_BEATS, 750, watchdog frame beat limit (used only with the optional feature).

Ports:
clk  in  1  clock
nreset  in  1  reset, synchronous, active-low
req_valid_i  in  REQ_N  per-requester beat valid
req_start_i  in  REQ_N  first beat of frame
req_last_i  in  REQ_N  final beat of frame
req_data_i  in  REQ_N*DATA_W  requester i at bits [i*DATA_W +: DATA_W]
req_len_i  in  REQ_N*LEN_W  byte count per requester
req_ready_o  out  REQ_N  beat accepted when valid & ready
valid_o  out  1  beat to UDP tx
start_o  out  1  first beat
last_o  out  1  final beat
data_o  out  DATA_W  muxed data
len_o  out  LEN_W  muxed byte count
ready_i  in  1  downstream accept
cancel_o  out  1  abort pulse for the current frame (watchdog only; tied 0 otherwise)
gnt_o  out  REQ_N  one-hot current grant, 0 when idle

Behaviour:
- Reset: state IDLE, gnt_q=0, ptr_q=0, beat counter=0. valid_o, start_o, last_o, cancel_o, req_ready_o and gnt_o are 0 in the cycle after reset. Reset mid-frame abandons the frame with no cancel_o.
- FSM states: IDLE, BUSY, DRAIN (DRAIN exists only with the feature).
- IDLE:
  - Candidate set = req_valid_i & req_start_i.
  - Winner = first set bit searching from ptr_q upward, wrapping modulo REQ_N.
  - If the set is non-empty: gnt_q <= one-hot winner, go to BUSY next cycle. This gives 1 cycle of grant latency.
  - Beats with valid & ~start are orphans: req_ready_o=1 for them and they are dropped, never forwarded.
  - Start beats are not readied in IDLE.
- BUSY, with g = granted index:
  - valid_o = req_valid_i[g]; start_o/last_o/data_o/len_o mux from g.
  - req_ready_o[g] = ready_i; all other ready bits are 0. Outputs are combinational from the inputs.
  - On the handshake of a last beat (valid_o & ready_i & last_o): ptr_q <= (g+1) mod REQ_N, gnt_q <= 0, go to IDLE.
  - This leaves one idle bubble cycle between frames.
  - A start beat from g while BUSY is forwarded unchanged; framing errors belong to the requester.
- Outside BUSY: valid_o, start_o and last_o are 0; data_o and len_o are don't-care.
- Simultaneous requests pick the first from ptr_q. A lone requester is regranted each frame.
- A single-beat frame (start and last both set) is legal: BUSY lasts one handshake.
- Downstream stall (ready_i=0) holds the state, grant and counter.

Optional Feature:
UDP_TX_ARB_WDOG_EN.
- Defined:
  - A 16-bit beat counter clears on grant and increments on each BUSY handshake.
  - If the count reaches MAX_BEATS without a last handshake, cancel_o pulses 1 cycle and the FSM enters DRAIN.
  - In DRAIN: valid_o=0; req_ready_o[g]=1; the requester's beats are dropped until its last beat is accepted, then ptr advances and the FSM goes to IDLE.
- Undefined: no counter, no DRAIN; cancel_o is constant 0.

Decomposition:
- Package udp_tx_arb_pkg holds:
  - the FSM state enum (IDLE/BUSY/DRAIN);
  - localparams CNT_W=16 and REQ_MAX=4;
  - the default MAX_BEATS.
- One sub-module, rr_pick: a combinational round-robin picker taking (req vector, ptr) and returning a one-hot winner. It is reusable by the rx-side port arbiter.

Test Plan:
- Req0 alone sends a 3-beat frame (0x1111, 0x2222, 0x3333 with last), ready_i=1 -> gnt_o=01 one cycle after start is presented; data_o shows those words on 3 consecutive cycles; back to IDLE; ptr=1.
- Req0 and req1 present start on the same cycle after reset -> req0 is granted first, then req1 after 1 bubble. A repeat contest is won by req1, then req0: alternating order.
- Grant to req1, ready_i low for 4 cycles mid-frame -> valid_o held high, data_o stable, req_ready_o=00 during the stall, no other grant.
- Req0 sends orphan beat 0xBEEF (no start) in IDLE -> req_ready_o[0]=1 that cycle; valid_o stays 0.
- With UDP_TX_ARB_WDOG_EN and MAX_BEATS=4: req0 sends 6 beats, last on beat 6 -> 4 beats forwarded; cancel_o pulses once; beats 5-6 are dropped with valid_o=0; IDLE after beat 6.
- Reset asserted mid-frame -> next cycle gnt_o=0, valid_o=0, ptr=0; the next start from req1 is granted normally.
